// File: rtl/nw_pkg.sv
// Shared codes for the alignment traceback path: column ops, decoder states and
// the grid step directions (TOP = up one row of s1, LEFT = back one column of s2).
package nw_pkg;

    typedef enum logic [1:0] {
        OP_MATCH    = 2'd0,
        OP_MISMATCH = 2'd1,
        OP_DEL      = 2'd2,
        OP_INS      = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        COLLECT,
        TERM,
        EMIT,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] TOP      = 2'd1;
    localparam logic [1:0] LEFT     = 2'd2;
    localparam logic [1:0] CORNER   = 2'd3;

endpackage

// File: rtl/nw_lifo.sv
// Column stack: push writes above the top, top_data is combinational from the top entry.
// One op per cycle; push+pop together replaces the top; push when full and pop when empty are ignored.
module nw_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNTW-1:0]  top_idx;
    logic             full;

    assign top_idx  = count - CNTW'(1);
    assign empty    = (count == '0);
    assign full     = (count == CNTW'(DEPTH));
    assign top_data = mem[top_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && pop && !empty) begin
            mem[top_idx[AW-1:0]] <= push_data;
        end else if (push && !full) begin
            mem[count[AW-1:0]] <= push_data;
            count              <= count + CNTW'(1);
        end else if (pop && !empty) begin
            count <= count - CNTW'(1);
        end
    end

endmodule

// File: rtl/nw_path_decoder.sv
// Turns a traceback coordinate stream (end -> origin) into alignment columns replayed in forward order.
// Columns stream out only after (0,0) arrives; out_ready low holds the current column steady.
module nw_path_decoder
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int SWIDTH      = 16,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int INDEL       = -1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CORD_LENGTH-1:0]     in_x,
    input  logic [CORD_LENGTH-1:0]     in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CWIDTH-1:0]          out_c1,
    output logic [CWIDTH-1:0]          out_c2,
    output logic                       out_gap1,
    output logic                       out_gap2,
    output logic [1:0]                 out_op,
    output logic                       out_last,
    output logic [CORD_LENGTH:0]       match_count,
    output logic [CORD_LENGTH:0]       mismatch_count,
    output logic [CORD_LENGTH:0]       gap_count,
    output logic signed [SWIDTH-1:0]   score,
    output logic                       done,
    output logic                       error
);

    localparam int DEPTH = 2 * LENGTH - 1;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int COLW  = 4 + 2 * CWIDTH;

    localparam logic [CORD_LENGTH:0]   ONE      = {{CORD_LENGTH{1'b0}}, 1'b1};
    localparam logic [CORD_LENGTH-1:0] LAST_IDX = CORD_LENGTH'(LENGTH - 1);
    localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
    localparam logic signed [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
    localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);

    state_t                 state;
    logic                   have_hold;
    logic [CORD_LENGTH-1:0] hold_x;
    logic [CORD_LENGTH-1:0] hold_y;

    logic [CORD_LENGTH:0]   nx1, ny1, nx0, ny0, hx, hy;
    logic [1:0]             step_dir;
    logic [1:0]             push_dir;
    logic [CWIDTH-1:0]      h_c1, h_c2;
    op_t                    push_op;
    logic [COLW-1:0]        push_col;
    logic [COLW-1:0]        top_col;
    logic                   push, pop, lifo_empty;
    logic [CNTW-1:0]        lifo_count;
    logic                   first_ok, at_origin;

    // Step classification compares with one extra bit so x+1 never wraps.
    assign nx0 = {1'b0, in_x};
    assign ny0 = {1'b0, in_y};
    assign nx1 = nx0 + ONE;
    assign ny1 = ny0 + ONE;
    assign hx  = {1'b0, hold_x};
    assign hy  = {1'b0, hold_y};

    always_comb begin
        step_dir = DIR_NONE;
        if (nx1 == hx && ny1 == hy)
            step_dir = CORNER;
        else if (nx0 == hx && ny1 == hy)
            step_dir = TOP;
        else if (nx1 == hx && ny0 == hy)
            step_dir = LEFT;
    end

    // Held coordinates are always inside the strings, so the mux needs no range guard.
    always_comb begin
        h_c1 = '0;
        h_c2 = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (hold_y == CORD_LENGTH'(i))
                h_c1 = s1[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
            if (hold_x == CORD_LENGTH'(i))
                h_c2 = s2[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
        end
    end

    assign push_dir = (state == TERM) ? CORNER : step_dir;

    always_comb begin
        case (push_dir)
            CORNER:  push_op = (h_c1 == h_c2) ? OP_MATCH : OP_MISMATCH;
            TOP:     push_op = OP_DEL;
            default: push_op = OP_INS;
        endcase
    end

    assign push_col = {push_op,
                       push_dir == LEFT,
                       push_dir == TOP,
                       (push_dir == LEFT) ? '0 : h_c1,
                       (push_dir == TOP)  ? '0 : h_c2};

    assign first_ok  = (in_x == LAST_IDX) && (in_y == LAST_IDX);
    assign at_origin = (in_x == '0) && (in_y == '0);

    assign push = (state == TERM) ||
                  (state == COLLECT && in_valid && have_hold && step_dir != DIR_NONE);
    assign pop  = out_valid && out_ready;

    assign in_ready  = (state == COLLECT) || (state == ERR);
    assign out_valid = (state == EMIT) && !lifo_empty;
    assign out_op    = top_col[COLW-1 -: 2];
    assign out_gap1  = top_col[2*CWIDTH+1];
    assign out_gap2  = top_col[2*CWIDTH];
    assign out_c1    = top_col[2*CWIDTH-1 -: CWIDTH];
    assign out_c2    = top_col[CWIDTH-1:0];
    assign out_last  = (lifo_count == CNTW'(1));

    nw_lifo #(
        .WIDTH (COLW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_col),
        .pop       (pop),
        .top_data  (top_col),
        .empty     (lifo_empty),
        .count     (lifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= COLLECT;
            have_hold      <= 1'b0;
            hold_x         <= '0;
            hold_y         <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            gap_count      <= '0;
            score          <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            if (push) begin
                case (push_op)
                    OP_MATCH: begin
                        match_count <= match_count + ONE;
                        score       <= score + W_MATCH;
                    end
                    OP_MISMATCH: begin
                        mismatch_count <= mismatch_count + ONE;
                        score          <= score + W_MISMATCH;
                    end
                    default: begin
                        gap_count <= gap_count + ONE;
                        score     <= score + W_INDEL;
                    end
                endcase
            end

            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (!have_hold) begin
                            if (first_ok) begin
                                have_hold <= 1'b1;
                                hold_x    <= in_x;
                                hold_y    <= in_y;
                                if (at_origin)
                                    state <= TERM;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
                        end else if (step_dir == DIR_NONE) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            hold_x <= in_x;
                            hold_y <= in_y;
                            if (at_origin)
                                state <= TERM;
                        end
                    end
                end
                TERM:    state <= EMIT;
                EMIT: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_path_decoder.sv
// Directed bench: expected columns queued at stimulus time, a negedge monitor pops and compares each handshake.
module tb_nw_path_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s1, s2;
    logic        in_valid, in_ready;
    logic [7:0]  in_x, in_y;
    logic        out_valid, out_ready;
    logic [1:0]  out_c1, out_c2;
    logic        out_gap1, out_gap2;
    logic [1:0]  out_op;
    logic        out_last;
    logic [8:0]  match_count, mismatch_count, gap_count;
    logic signed [15:0] score;
    logic        done, error;

    typedef struct packed {
        logic [1:0] c1;
        logic [1:0] c2;
        logic       g1;
        logic       g2;
        logic [1:0] op;
        logic       last;
    } beat_t;

    beat_t sb[$];
    beat_t held;
    logic  held_v = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    ov_seen = 0;

    always #5 clk = ~clk;

    nw_path_decoder #(
        .LENGTH(4), .CWIDTH(2), .CORD_LENGTH(8), .SWIDTH(16),
        .MATCH(1), .MISMATCH(-1), .INDEL(-1)
    ) dut (
        .clk(clk), .reset(reset), .s1(s1), .s2(s2),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c1(out_c1), .out_c2(out_c2), .out_gap1(out_gap1), .out_gap2(out_gap2),
        .out_op(out_op), .out_last(out_last),
        .match_count(match_count), .mismatch_count(mismatch_count), .gap_count(gap_count),
        .score(score), .done(done), .error(error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [1:0] c1, input logic [1:0] c2, input logic g1,
                            input logic g2, input logic [1:0] op, input logic last);
        beat_t b;
        b = '{c1: c1, c2: c2, g1: g1, g2: g2, op: op, last: last};
        sb.push_back(b);
    endtask

    // Monitor: scoreboard on every handshake, stability whenever a presented column was stalled.
    always @(negedge clk) begin
        beat_t cur;
        cur = {out_c1, out_c2, out_gap1, out_gap2, out_op, out_last};
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (out_valid) ov_seen++;
            if (out_valid && held_v)
                chk("stall_hold", 32'(cur), 32'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", 32'(cur), 32'h1ff);
                end else begin
                    chk("beat", 32'(cur), 32'(sb.pop_front()));
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held   = cur;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_arrives", 32'(out_valid), 32'd1);
    endtask

    task automatic diag_path();
        exp_beat(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_beat(2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_beat(2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_beat(2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1);
        send(8'd3, 8'd3);
        send(8'd2, 8'd2);
        send(8'd1, 8'd1);
        send(8'd0, 8'd0);
    endtask

    task automatic chk_counts(input string tag, input int m, input int mm, input int g, input int sc);
        chk({tag, "_match"},    32'(match_count),    32'(m));
        chk({tag, "_mismatch"}, 32'(mismatch_count), 32'(mm));
        chk({tag, "_gap"},      32'(gap_count),      32'(g));
        chk({tag, "_score"},    32'(score),          32'(sc));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        s1        = 8'h1B;
        s2        = 8'h1B;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk_counts("rst", 0, 0, 0, 0);

        // All-diagonal path on identical strings.
        diag_path();
        wait_done(60);
        chk_counts("diag", 4, 0, 0, 4);
        chk("diag_left", sb.size(), 0);
        chk("diag_in_ready", 32'(in_ready), 32'd0);

        // Gapped path: DEL at the end, INS near the origin.
        do_reset();
        s2 = 8'h1F;
        exp_beat(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_beat(2'd0, 2'd1, 1'b1, 1'b0, 2'd3, 1'b0);
        exp_beat(2'd1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b0);
        exp_beat(2'd2, 2'd3, 1'b0, 1'b0, 2'd1, 1'b0);
        exp_beat(2'd3, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1);
        send(8'd3, 8'd3);
        send(8'd3, 8'd2);
        send(8'd2, 8'd1);
        send(8'd1, 8'd0);
        send(8'd0, 8'd0);
        wait_done(60);
        chk_counts("gap", 1, 2, 2, -3);
        chk("gap_left", sb.size(), 0);

        // Bad first coordinate.
        do_reset();
        s2 = 8'h1B;
        ov_seen = 0;
        send(8'd2, 8'd3);
        chk("badfirst_error", 32'(error), 32'd1);
        chk("badfirst_in_ready", 32'(in_ready), 32'd1);
        send(8'd3, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("badfirst_sticky", 32'(error), 32'd1);
        chk("badfirst_no_out", ov_seen, 0);

        // Illegal step after a valid start.
        do_reset();
        ov_seen = 0;
        send(8'd3, 8'd3);
        send(8'd1, 8'd2);
        chk("badstep_error", 32'(error), 32'd1);
        send(8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_counts("badstep", 0, 0, 0, 0);
        chk("badstep_no_out", ov_seen, 0);
        chk("badstep_done", 32'(done), 32'd0);

        // Three-cycle stall in the middle of the emit phase.
        do_reset();
        out_ready = 1'b0;
        diag_path();
        wait_valid(20);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(60);
        chk_counts("stall", 4, 0, 0, 4);
        chk("stall_left", sb.size(), 0);

        // Reset while the second column is presented.
        do_reset();
        out_ready = 1'b0;
        diag_path();
        wait_valid(20);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk_counts("midrst", 0, 0, 0, 0);
        chk("midrst_consumed", sb.size(), 3);
        sb.delete();
        diag_path();
        wait_done(60);
        chk_counts("after_rst", 4, 0, 0, 4);
        chk("after_rst_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nw_path_decoder.md
NW_PATH_DECODER -- requirements
Module: nw_path_decoder

Interface
REQ-001 SHALL have parameter LENGTH, default 10: characters per string.
REQ-002 SHALL have parameter CWIDTH, default 2: bits per character.
REQ-003 SHALL have parameter CORD_LENGTH, default 8: bits per coordinate.
REQ-004 SHALL have parameter SWIDTH, default 16: score width; MATCH=1, MISMATCH=-1, INDEL=-1 signed weight parameters.
REQ-005 SHALL have port clk input 1: the single clock.
REQ-006 SHALL have port reset input 1: synchronous, active-high.
REQ-007 SHALL have ports s1, s2 input LENGTH*CWIDTH: strings, char i at bits [((LENGTH-1)-i)*CWIDTH +: CWIDTH], stable for the whole operation.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_x input CORD_LENGTH, in_y input CORD_LENGTH: traceback coordinate stream (x indexes s2, y indexes s1).
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_c1/out_c2 output CWIDTH, out_gap1/out_gap2 output 1, out_op output 2, out_last output 1: alignment column stream.
REQ-010 SHALL have ports match_count, mismatch_count, gap_count output CORD_LENGTH+1; score output SWIDTH signed; done output 1; error output 1.

Function
REQ-011 SHALL implement states COLLECT, TERM, EMIT, DONE, ERR; in_ready=1 only in COLLECT and ERR (ERR discards input).
REQ-012 First accepted coordinate SHALL be (LENGTH-1, LENGTH-1), else next state ERR.
REQ-013 Each accepted coordinate SHALL be held; on the next accepted coordinate the held one's column SHALL be pushed: both x,y decreased by 1 -> s1[y] vs s2[x]; only y decreased by 1 -> s1[y] vs gap (OP_DEL); only x decreased by 1 -> gap vs s2[x] (OP_INS); any other step -> ERR, no push.
REQ-014 Paired column op SHALL be OP_MATCH if chars equal, else OP_MISMATCH.
REQ-015 Accepting (0,0) SHALL push the held column and enter TERM; TERM SHALL push the (0,0) pair column (s1[0] vs s2[0]) in one cycle, then enter EMIT.
REQ-016 Columns SHALL be stored in a LIFO of depth 2*LENGTH-1; EMIT SHALL present columns in forward order (last pushed first) combinationally from the top entry, pop on out_valid&&out_ready.
REQ-017 out_* data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_last=1 SHALL accompany the final column; its handshake SHALL enter DONE; done=1 held in DONE until reset.
REQ-019 Counters SHALL increment on push by op class (OP_INS and OP_DEL both -> gap_count); score SHALL equal MATCH*match_count+MISMATCH*mismatch_count+INDEL*gap_count, sign-extended to SWIDTH, valid when done=1.
REQ-020 error SHALL be sticky in ERR; out_valid SHALL stay 0 in ERR, TERM, COLLECT.

Reset
REQ-021 reset SHALL, in the cycle it is sampled high, force state COLLECT, empty LIFO, clear holding register, counters, score, done, error, out_valid to 0; in_ready=1 next cycle.
REQ-022 reset SHALL take priority over any simultaneous handshake, including mid-EMIT.

Structure
REQ-023 Package nw_pkg SHALL hold op codes (OP_MATCH=0, OP_MISMATCH=1, OP_DEL=2, OP_INS=3), the state enum and the TOP/LEFT/CORNER direction constants shared with the grid.
REQ-024 SHALL instantiate one sub-module nw_lifo (push, pop, top data, empty, count) for the column buffer.

Verification (LENGTH=4, s1=s2=8'h1B unless stated)
REQ-025 Path (3,3),(2,2),(1,1),(0,0) -> 4 beats OP_MATCH, chars 0,1,2,3, out_last on 4th, match_count=4, score=4, done=1.
REQ-026 s2=8'h1F, path (3,3),(3,2),(2,1),(1,0),(0,0) -> 5 beats: (0,0) pair, gap vs s2[1] OP_INS, two pairs, s1[3] vs gap OP_DEL; gap_count=2.
REQ-027 First coordinate (2,3) -> error=1, in_ready=1, out_valid never asserted.
REQ-028 Step (3,3)->(1,2) -> error=1, no further pushes.
REQ-029 out_ready=0 for 3 cycles mid-EMIT -> out_* unchanged, no beat lost or repeated.
REQ-030 reset high during EMIT beat 2 -> out_valid=0, counters=0, done=0 next cycle; new path then decodes correctly.
